// File: rtl/bin_to_bcd_display.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding a 4-digit display.
// Optional macro BCD_CONV_SAT_EN saturates the displayed value to 9999 on overflow.
module bin_to_bcd_display #(
  parameter int BIN_W = 16
) (
  input  logic             Bcd_Conv_clk,
  input  logic             Bcd_Conv_rst_n,
  input  logic             Bcd_Conv_start,
  input  logic [BIN_W-1:0] Bcd_Conv_bin,
  output logic             Bcd_Conv_busy,
  output logic             Bcd_Conv_done,
  output logic [15:0]      Bcd_Conv_data,
  output logic             Bcd_Conv_ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [19:0]      bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      data_q, data_d;
  logic             ovf_q, ovf_d;

  logic [19:0]      bcd_adj, bcd_sh;
  logic [BIN_W-1:0] bin_sh;
  logic             ovf_nxt;

  // Digits never exceed 9 after a shift, so a 4-bit add per nibble cannot carry.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 5; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                    : bcd_q[4*i +: 4];
    end
  end

  assign {bcd_sh, bin_sh} = {bcd_adj, bin_q} << 1;
  assign ovf_nxt = |bcd_sh[19:16];

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (Bcd_Conv_start) begin
          bin_d   = Bcd_Conv_bin;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + 5'd1;
        // Outputs load on the final shift so they are valid during the done cycle.
        if (cnt_q == 5'(BIN_W - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = ovf_nxt;
`ifdef BCD_CONV_SAT_EN
          data_d  = ovf_nxt ? 16'h9999 : bcd_sh[15:0];
`else
          data_d  = bcd_sh[15:0];
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Bcd_Conv_clk or negedge Bcd_Conv_rst_n) begin
    if (!Bcd_Conv_rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Bcd_Conv_busy = busy_q;
  assign Bcd_Conv_done = done_q;
  assign Bcd_Conv_data = data_q;
  assign Bcd_Conv_ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Randomized self-checking bench for bin_to_bcd_display against a decimal-arithmetic model.
module tb_bin_to_bcd_display;

  localparam int BIN_W = 16;
  localparam int LAT   = BIN_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, ovf;
  logic [15:0] data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  bin_to_bcd_display #(.BIN_W(BIN_W)) dut (
    .Bcd_Conv_clk  (clk),
    .Bcd_Conv_rst_n(rst_n),
    .Bcd_Conv_start(start),
    .Bcd_Conv_bin  (bin),
    .Bcd_Conv_busy (busy),
    .Bcd_Conv_done (done),
    .Bcd_Conv_data (data),
    .Bcd_Conv_ovf  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_ovf(input int v);
    return v > 9999;
  endfunction

  function automatic logic [15:0] ref_data(input int v);
    int m;
    m = v % 10000;
`ifdef BCD_CONV_SAT_EN
    if (v > 9999) m = 9999;
`endif
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Launch one conversion, measure edges from accept to done, and check results.
  task automatic conv(input int v, input string tag);
    int lat;
    @(negedge clk);
    start = 1'b1;
    bin   = 16'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      lat++;
    end while (lat < 40);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_data"}, data, ref_data(v));
    chk({tag, "_ovf"}, ovf, ref_ovf(v));
    @(negedge clk);
    chk({tag, "_busy_after"}, {busy, done}, 2'b00);
    chk({tag, "_hold"}, data, ref_data(v));
  endtask

  initial begin
    int d0, n, v;
    int t[4];
    int vals[4];
    vals = '{1, 10, 100, 1000};

    #2;
    chk("rst_state", {busy, done, ovf, data}, 19'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    conv(1234, "t1234");
    conv(0, "t0");
    conv(9999, "t9999");
    conv(65535, "t65535");
    conv(10000, "t10000");

    // Start during a conversion is ignored.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; bin = 16'd42;
    @(negedge clk);
    start = 1'b0; bin = 16'd0;
    repeat (3) @(negedge clk);
    start = 1'b1; bin = 16'd77;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("ign_data", data, 16'h0042);
    repeat (25) @(negedge clk);
    chk("ign_one_done", done_cnt - d0, 1);

    // Async reset mid-conversion discards it.
    @(negedge clk);
    start = 1'b1; bin = 16'd5000;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid", {busy, done, ovf, data}, 19'h0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    conv(5000, "t5000");

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; bin = 16'(vals[0]);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!done && n < 60) begin @(negedge clk); n++; end
      t[k] = cyc;
      chk($sformatf("b2b_data%0d", k), data, ref_data(vals[k]));
      if (k < 3) bin = 16'(vals[k+1]);
      else start = 1'b0;
      if (k > 0) chk($sformatf("b2b_period%0d", k), t[k] - t[k-1], BIN_W + 2);
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      v = (i % 4 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      conv(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
